bitwise_logic_pipe: RTL and testbench
=====================================

// Module: bitwise_logic_pipe
// PURPOSE
//  Parametrised, pipelined successor to the ALU's two-op AND/OR logic slice: 8 bitwise ops on WIDTH-bit
//  operands, 2-stage valid/ready pipeline with backpressure, tag passthrough, zero/parity flags,
//  illegal-op detection and a retired-op counter. Sits between EX operand muxes and the writeback arbiter.
// PARAMETERS
//  WIDTH   32  operand/result width (>=1)
//  TAG_W   5   width of opaque tag carried with each op (e.g. dest reg)
//  CNT_W   16  width of retired-op counter (wraps)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        op presented
//  in_ready   out  1        pipe accepts op this cycle
//  in_op      in   4        opcode (below)
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_tag     in   TAG_W    tag, returned unchanged
//  out_valid  out  1        result presented
//  out_ready  in   1        consumer accepts result
//  out_result out  WIDTH    op result
//  out_tag    out  TAG_W    tag of this result
//  out_zero   out  1        out_result == 0
//  out_parity out  1        XOR-reduce of out_result
//  out_illegal out 1        opcode was illegal
//  retired    out  CNT_W    count of output handshakes
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN a&~b, 5 ORN a|~b, 6 XNOR, 7 PASSA.
//   8..15 illegal: result 0, illegal=1 (zero=1, parity=0); op still flows and retires normally.
//  Accept when in_valid&in_ready; deliver when out_valid&out_ready.
//  Stage S1: registers op result, tag, illegal. Stage S2: registers S1 data + zero/parity flags.
//   All outputs driven directly from S2 registers (no combinational in->out path).
//  adv2 = s2_v & out_ready; s2 loads when !s2_v | adv2; s1 moves to s2 on that same condition.
//  in_ready = !s1_v | (s2 loads) -- combinational from out_ready; no bubble at full throughput.
//  Latency: 2 cycles accept->out_valid when unstalled; throughput 1 op/cycle.
//  Stall: out_valid & !out_ready -> S2 holds; all out_* stable until handshake (no change while valid).
//  Both stages full and stalled -> in_ready=0; in_a/b/op ignored.
//  Simultaneous accept+deliver with both full: S2<-S1, S1<-new, retired+1, same cycle.
//  Order preserved; no op dropped or duplicated.
//  retired increments by 1 per output handshake; wraps 2^CNT_W-1 -> 0.
//  Reset (sync, any cycle incl. mid-stall): s1_v=s2_v=0, out_valid=0, out_result=0, out_tag=0,
//   out_zero=0, out_parity=0, out_illegal=0, retired=0; in-flight ops discarded.
//   in_ready=1 in the first cycle after reset deasserts.
//  Data registers need no reset for correctness but are reset to 0 for deterministic outputs.
// TESTING
//  1 Reset: hold reset 2 cycles mid-stream -> out_valid=0, retired=0, in_ready=1 next cycle.
//  2 Ops: WIDTH=32, a=F0F0_00FF b=FF00_0F0F, op0..7 -> F000_000F, FFF0_0FFF, 0FF0_0FF0, 000F_F000,
//    00F0_00F0, F0FF_F0FF, F00F_F00F, F0F0_00FF; each out 2 cycles after accept, tags match.
//  3 Flags/illegal: op 9 a=b=FFFF_FFFF -> result 0, illegal=1, zero=1, parity=0; op2 a=1 b=0 -> parity=1.
//  4 Backpressure: 5 back-to-back ops, out_ready=0 for 4 cycles -> in_ready drops after 2 accepted,
//    out_* stable; release -> all 5 delivered in order, no gaps, retired=5.
//  5 Throughput: in_valid=out_ready=1 for 100 cycles -> 98 outputs in window, in_ready constant 1.
//  6 Wrap: CNT_W=4, 17 handshakes -> retired=1; random valid/ready vs scoreboard model, 10k ops.

Source files
------------

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline for eight bitwise operations on WIDTH-bit operands.
// Each operation carries a tag through the pipe unchanged. Results leave the pipe with
// zero and parity flags and an illegal-opcode flag. A wrapping counter tracks how many
// results have been handed to the consumer.
module bitwise_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_result_q, s1_result_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_illegal_q, s1_illegal_d;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_parity_q, s2_parity_d;

  logic [CNT_W-1:0] retired_q, retired_d;

  logic [WIDTH-1:0] op_result;
  logic             op_illegal;
  logic             adv2;
  logic             s2_load;
  logic             accept;

  // Decode the opcode and compute the bitwise result; opcodes 8..15 produce zero and flag illegal
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (in_op)
      4'd0:    op_result = in_a & in_b;
      4'd1:    op_result = in_a | in_b;
      4'd2:    op_result = in_a ^ in_b;
      4'd3:    op_result = ~(in_a | in_b);
      4'd4:    op_result = in_a & ~in_b;
      4'd5:    op_result = in_a | ~in_b;
      4'd6:    op_result = ~(in_a ^ in_b);
      4'd7:    op_result = in_a;
      default: op_illegal = 1'b1;
    endcase
  end

  // Handshake control: S2 refills whenever it is empty or draining, and S1 may accept whenever it can hand off
  always_comb begin
    adv2     = s2_v_q & out_ready;
    s2_load  = ~s2_v_q | adv2;
    in_ready = ~s1_v_q | s2_load;
    accept   = in_valid & in_ready;
  end

  // Stage 1 captures a new operation on accept and empties when its content moves on to S2
  always_comb begin
    s1_v_d       = accept | (s1_v_q & ~s2_load);
    s1_result_d  = s1_result_q;
    s1_tag_d     = s1_tag_q;
    s1_illegal_d = s1_illegal_q;
    if (accept) begin
      s1_result_d  = op_result;
      s1_tag_d     = in_tag;
      s1_illegal_d = op_illegal;
    end
  end

  // Stage 2 takes S1 contents plus the derived flags, and holds everything while the consumer stalls
  always_comb begin
    s2_v_d       = s2_load ? s1_v_q : s2_v_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_illegal_d = s2_illegal_q;
    s2_zero_d    = s2_zero_q;
    s2_parity_d  = s2_parity_q;
    if (s2_load && s1_v_q) begin
      s2_result_d  = s1_result_q;
      s2_tag_d     = s1_tag_q;
      s2_illegal_d = s1_illegal_q;
      s2_zero_d    = ~(|s1_result_q);
      s2_parity_d  = ^s1_result_q;
    end
  end

  // Count every output handshake, wrapping naturally at the counter width
  always_comb begin
    retired_d = retired_q + CNT_W'(adv2);
  end

  // State registers; reset clears validity and data so outputs are deterministic
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q       <= 1'b0;
      s1_result_q  <= '0;
      s1_tag_q     <= '0;
      s1_illegal_q <= 1'b0;
      s2_v_q       <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_parity_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_result_q  <= s1_result_d;
      s1_tag_q     <= s1_tag_d;
      s1_illegal_q <= s1_illegal_d;
      s2_v_q       <= s2_v_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
      s2_zero_q    <= s2_zero_d;
      s2_parity_q  <= s2_parity_d;
      retired_q    <= retired_d;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_zero    = s2_zero_q;
  assign out_parity  = s2_parity_q;
  assign out_illegal = s2_illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed scenarios followed by random
// valid/ready traffic. A transaction-level queue model predicts every output.
module tb_bitwise_logic_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_parity;
  logic             out_illegal;
  logic [CNT_W-1:0] retired;

  bitwise_logic_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_parity(out_parity),
    .out_illegal(out_illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             ill;
    int               acc;
  } item_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             par;
    logic             ill;
  } obs_t;

  item_t modelQ[$];
  obs_t  deliveredLog[$];
  int    retiredModel;
  int    cyc;
  int    checks;
  int    failures;
  bit    lastAcc;
  bit    lastDlv;

  // Reference: each opcode is a 2-input truth table indexed by {a_bit, b_bit}
  function automatic void refOp(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] res, output logic ill);
    logic [3:0] tt;
    ill = 1'b0;
    case (op)
      4'd0: tt = 4'b1000;
      4'd1: tt = 4'b1110;
      4'd2: tt = 4'b0110;
      4'd3: tt = 4'b0001;
      4'd4: tt = 4'b0100;
      4'd5: tt = 4'b1101;
      4'd6: tt = 4'b1001;
      4'd7: tt = 4'b1100;
      default: begin tt = 4'b0000; ill = 1'b1; end
    endcase
    for (int i = 0; i < WIDTH; i++) res[i] = tt[{a[i], b[i]}];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", name, observed, expected, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update the model at the edge
  task automatic applyStimulus(input bit iv, input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                               input bit ordy);
    bit expValid, expReady;
    logic [WIDTH-1:0] r;
    logic il;
    in_valid = iv; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
    #1;
    expValid = (modelQ.size() > 0) && (cyc >= modelQ[0].acc + 2);
    expReady = (modelQ.size() < 2) || ordy;
    checkOutput("out_valid", 64'(out_valid), 64'(expValid));
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    checkOutput("retired", 64'(retired), 64'(retiredModel));
    if (expValid) begin
      r = modelQ[0].res;
      checkOutput("out_result", 64'(out_result), 64'(r));
      checkOutput("out_tag", 64'(out_tag), 64'(modelQ[0].tag));
      checkOutput("out_illegal", 64'(out_illegal), 64'(modelQ[0].ill));
      checkOutput("out_zero", 64'(out_zero), 64'(r == '0));
      checkOutput("out_parity", 64'(out_parity), 64'(^r));
    end
    lastAcc = iv && expReady;
    lastDlv = expValid && ordy;
    if (lastDlv) begin
      deliveredLog.push_back('{res: out_result, tag: out_tag, zero: out_zero,
                               par: out_parity, ill: out_illegal});
      void'(modelQ.pop_front());
      retiredModel = (retiredModel + 1) % (1 << CNT_W);
    end
    if (lastAcc) begin
      refOp(op, a, b, r, il);
      modelQ.push_back('{res: r, tag: tag, ill: il, acc: cyc});
    end
    @(posedge clock); #1; cyc++;
  endtask

  task automatic resetPipe();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin @(posedge clock); #1; cyc++; end
    modelQ.delete();
    retiredModel = 0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_retired", 64'(retired), 64'd0);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_flags", 64'({out_zero, out_parity, out_illegal}), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (modelQ.size() > 0 && n < bound) begin
      applyStimulus(1'b0, 4'd0, '0, '0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_empty", 64'(modelQ.size()), 64'd0);
  endtask

  task automatic sendOne(input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    int n = 0;
    do begin
      applyStimulus(1'b1, op, a, b, tag, 1'b1);
      n++;
    end while (!lastAcc && n < 20);
    checkOutput("send_accepted", 64'(lastAcc), 64'd1);
  endtask

  // Safety net in case a wait escapes its bound
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] opExp [8];
    int idx, nDlv, nStall, retBase, accepted, budget;
    logic [3:0] rop;
    opExp = '{32'hF000_000F, 32'hFFF0_0FFF, 32'h0FF0_0FF0, 32'h000F_F000,
              32'h00F0_00F0, 32'hF0FF_F0FF, 32'hF00F_F00F, 32'hF0F0_00FF};
    checks = 0; failures = 0; cyc = 0; retiredModel = 0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    $display("[TB] reset from power-up");
    resetPipe();

    $display("[TB] directed opcode vectors");
    deliveredLog.delete();
    for (int k = 0; k < 8; k++) sendOne(4'(k), 32'hF0F0_00FF, 32'hFF00_0F0F, 5'(k));
    drain(10);
    checkOutput("ops_count", 64'(deliveredLog.size()), 64'd8);
    if (deliveredLog.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        checkOutput("ops_result", 64'(deliveredLog[k].res), 64'(opExp[k]));
        checkOutput("ops_tag", 64'(deliveredLog[k].tag), 64'(k));
      end
    end

    $display("[TB] flags and illegal opcode");
    deliveredLog.delete();
    sendOne(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    sendOne(4'd2, 32'h1, 32'h0, 5'd10);
    drain(10);
    checkOutput("flags_count", 64'(deliveredLog.size()), 64'd2);
    if (deliveredLog.size() == 2) begin
      checkOutput("ill_result", 64'(deliveredLog[0].res), 64'd0);
      checkOutput("ill_flags", 64'({deliveredLog[0].ill, deliveredLog[0].zero, deliveredLog[0].par}), 64'b110);
      checkOutput("xor_parity", 64'({deliveredLog[1].ill, deliveredLog[1].zero, deliveredLog[1].par}), 64'b001);
    end

    $display("[TB] backpressure");
    deliveredLog.delete();
    retBase = retiredModel;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 4'(idx % 8), $urandom, $urandom, 5'(16 + idx), 1'b0);
      if (lastAcc) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    nDlv = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(idx < 5, 4'(idx % 8), $urandom, $urandom, 5'(16 + idx), 1'b1);
      if (lastAcc) idx++;
      if (lastDlv) nDlv++;
    end
    checkOutput("bp_no_gaps", 64'(nDlv), 64'd5);
    checkOutput("bp_all_in", 64'(idx), 64'd5);
    checkOutput("bp_retired", 64'(retired), 64'((retBase + 5) % 16));
    if (deliveredLog.size() == 5)
      for (int k = 0; k < 5; k++) checkOutput("bp_order", 64'(deliveredLog[k].tag), 64'(16 + k));
    drain(10);

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 4'd1, $urandom, $urandom, 5'd3, 1'b0);
    applyStimulus(1'b1, 4'd2, $urandom, $urandom, 5'd4, 1'b0);
    applyStimulus(1'b1, 4'd3, $urandom, $urandom, 5'd5, 1'b0);
    resetPipe();
    applyStimulus(1'b0, 4'd0, '0, '0, '0, 1'b0);

    $display("[TB] full throughput");
    nDlv = 0; nStall = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'b1);
      if (lastDlv) nDlv++;
      if (!in_ready) nStall++;
    end
    checkOutput("tp_outputs", 64'(nDlv), 64'd98);
    checkOutput("tp_in_ready_low", 64'(nStall), 64'd0);
    drain(10);

    $display("[TB] counter wrap");
    resetPipe();
    for (int k = 0; k < 17; k++) sendOne(4'(k % 8), $urandom, $urandom, 5'(k));
    drain(10);
    checkOutput("wrap_retired", 64'(retired), 64'd1);

    $display("[TB] random traffic");
    accepted = 0; budget = 0;
    while (accepted < 10000 && budget < 60000) begin
      rop = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, rop, $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 3) != 0);
      if (lastAcc) accepted++;
      budget++;
    end
    checkOutput("rand_accepted", 64'(accepted), 64'd10000);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
